pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
Next-PC controller and fetch sequencer for the 64-bit RISC-V core.
- Drives PC_In of Program_Counter and reads back its PC_Out.
- Issues instruction-memory reads and holds fetched instructions in a one-entry fetch buffer for decode.
- Applies redirects (branch/jump), traps, decode stalls and misaligned-target faults, with fixed priority and a one-cycle bubble after every redirect.

Parameters:
XLEN, 64, address/PC width
RESET_VECTOR, 64'h0, PC loaded out of reset
TRAP_VECTOR, 64'h100, PC loaded on trap or misaligned redirect
INSN_W, 32, instruction width

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
pc_cur  in  XLEN  current PC (Program_Counter.PC_Out)
pc_next  out  XLEN  next PC (to Program_Counter.PC_In), combinational
imem_req  out  1  fetch request at imem_addr this cycle
imem_addr  out  XLEN  equals pc_cur
imem_gnt  in  1  memory returns imem_rdata this cycle (wait states = gnt low)
imem_rdata  in  INSN_W  instruction data, valid when imem_req && imem_gnt
id_stall  in  1  decode cannot accept the buffered instruction
redirect_valid  in  1  branch/jump taken
redirect_target  in  XLEN  redirect address
trap_valid  in  1  exception/interrupt request
if_valid  out  1  fetch buffer holds an instruction
if_pc  out  XLEN  PC of buffered instruction
if_insn  out  INSN_W  buffered instruction
misalign_err  out  1  one-cycle pulse: redirect target bits [1:0] != 0
fault_pc  out  XLEN  last misaligned target
fetch_count  out  32  completed fetches, wraps modulo 2^32

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=BOOT; if_valid=0; if_pc=0; if_insn=0; misalign_err=0; fault_pc=0; fetch_count=0.
- While reset is high, pc_next=RESET_VECTOR and imem_req=0.
- States:
  - BOOT: pc_next=RESET_VECTOR, imem_req=0; next state RUN.
  - RUN: normal fetch.
  - BUBBLE: one cycle after a redirect or trap; imem_req=0, pc_next=pc_cur; next state RUN.
- Event priority, evaluated each cycle in RUN or BUBBLE:
  - reset > trap_valid > redirect_valid > stall/fetch.
- trap_valid:
  - pc_next=TRAP_VECTOR; if_valid<=0; next state BUBBLE.
  - Applies regardless of id_stall.
- redirect_valid, aligned target:
  - pc_next=redirect_target; if_valid<=0; next state BUBBLE.
- redirect_valid, misaligned target:
  - pc_next=TRAP_VECTOR; fault_pc<=redirect_target; misalign_err<=1 for one cycle; if_valid<=0; next state BUBBLE.
- Redirect or trap arriving during BUBBLE: accepted; newest target wins; stays in BUBBLE one more cycle.
- RUN, no redirect or trap:
  - buf_free = !if_valid || !id_stall.
  - imem_req = buf_free.
  - Transfer (imem_req && imem_gnt):
    - if_valid<=1; if_pc<=pc_cur; if_insn<=imem_rdata.
    - pc_next=pc_cur+4, wrapping modulo 2^XLEN.
    - fetch_count<=fetch_count+1.
  - No transfer, buffer consumed (if_valid && !id_stall): if_valid<=0; pc_next=pc_cur.
  - Otherwise: all outputs hold; pc_next=pc_cur.
- imem_req may deassert without a grant. The memory treats every cycle independently, so there is no outstanding-request tracking.
- Latency:
  - Grant in cycle N -> instruction on if_* in N+1 and PC advanced in N+1.
  - Redirect in cycle N -> PC=target in N+1 (bubble) -> fetch of target in N+2.
- if_pc and if_insn stay stable while if_valid && id_stall.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN and INSN_W.
  - Default RESET_VECTOR and TRAP_VECTOR.
  - PC increment constant 4.
  - State enum {BOOT, RUN, BUBBLE}.
- No sub-module; the block stays flat, as the buffer and next-PC mux are too small to split.

Test Plan:
1. reset 2 cycles, then gnt=1, stall=0 -> BOOT cycle, then imem_addr 0x0,0x4,0x8,0xC on consecutive cycles; if_pc lags one cycle; fetch_count=4 after 4 grants.
2. imem_gnt=0 for 3 cycles at pc_cur=0x8 -> pc_next=0x8 and imem_req=1 throughout; if_valid drops after consumption; gnt=1 -> if_pc=0x8 next cycle.
3. id_stall=1 for 2 cycles with if_pc=0x4 buffered -> imem_req=0, if_pc/if_insn stable, pc_cur stays 0x8; stall=0 -> 0x8 fetched.
4. redirect_valid, target 0x40, at pc_cur=0x10 -> next cycle pc_cur=0x40, if_valid=0, imem_req=0; following cycle imem_addr=0x40.
5. redirect target 0x42 -> pc_cur=0x100, misalign_err one cycle, fault_pc=0x42. trap_valid together with redirect to 0x40 -> pc_cur=0x100.
6. PC at 64'hFFFF_FFFF_FFFF_FFFC with grant -> pc_next=0. reset during stall with if_valid=1 -> next edge if_valid=0, fetch_count=0, pc_next=RESET_VECTOR.

Source files
------------

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the 64-bit RISC-V fetch path.
// Holds the default datapath widths, reset/trap vectors, the sequential PC
// increment and the fetch sequencer state type.
package riscv_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned INSN_W = 32;

    localparam logic [63:0] RESET_VECTOR_DEFAULT = 64'h0;
    localparam logic [63:0] TRAP_VECTOR_DEFAULT  = 64'h100;

    // Fixed-length 32-bit instructions, no compressed support.
    localparam int unsigned PC_INC = 4;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        BUBBLE
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bus: instruction-memory request/grant and the fetch buffer
// presented to decode.
//   master (sequencer): drives imem_req, imem_addr, if_valid, if_pc, if_insn;
//                       samples imem_gnt, imem_rdata, id_stall
//   slave  (memory + decode): the mirror image
interface pc_fetch_sequencer_if #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned INSN_W = 32
);

    logic              imem_req;
    logic [XLEN-1:0]   imem_addr;
    logic              imem_gnt;
    logic [INSN_W-1:0] imem_rdata;
    logic              id_stall;
    logic              if_valid;
    logic [XLEN-1:0]   if_pc;
    logic [INSN_W-1:0] if_insn;

    modport master (
        output imem_req,
        output imem_addr,
        output if_valid,
        output if_pc,
        output if_insn,
        input  imem_gnt,
        input  imem_rdata,
        input  id_stall
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        input  if_valid,
        input  if_pc,
        input  if_insn,
        output imem_gnt,
        output imem_rdata,
        output id_stall
    );

endinterface

// File: rtl/pc_fetch_sequencer.sv
// Next-PC controller and fetch sequencer.
// Computes the Program_Counter input every cycle, issues instruction-memory
// reads at the current PC and keeps the most recent instruction in a
// one-entry buffer for decode. Traps beat redirects, redirects beat normal
// fetch; every redirect or trap is followed by a one-cycle bubble.
// Ports:
//   clock, reset    : clock and synchronous active-high reset
//   pc_cur          : Program_Counter output
//   pc_next         : Program_Counter input (combinational)
//   bus             : imem request/grant and fetch buffer (master side)
//   redirect_valid  : taken branch/jump, target on redirect_target
//   trap_valid      : exception/interrupt request
//   misalign_err    : one-cycle pulse after a misaligned redirect
//   fault_pc        : most recent misaligned redirect target
//   fetch_count     : completed fetches, wraps at 2^32
module pc_fetch_sequencer #(
    parameter int unsigned     XLEN         = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = riscv_pkg::RESET_VECTOR_DEFAULT[XLEN-1:0],
    parameter logic [XLEN-1:0] TRAP_VECTOR  = riscv_pkg::TRAP_VECTOR_DEFAULT[XLEN-1:0],
    parameter int unsigned     INSN_W       = riscv_pkg::INSN_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [XLEN-1:0]       pc_cur,
    output logic [XLEN-1:0]       pc_next,
    pc_fetch_sequencer_if.master  bus,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_target,
    input  logic                  trap_valid,
    output logic                  misalign_err,
    output logic [XLEN-1:0]       fault_pc,
    output logic [31:0]           fetch_count
);

    import riscv_pkg::*;

    fetch_state_e      state_q, state_d;
    logic              if_valid_q, if_valid_d;
    logic [XLEN-1:0]   if_pc_q, if_pc_d;
    logic [INSN_W-1:0] if_insn_q, if_insn_d;
    logic              misalign_q, misalign_d;
    logic [XLEN-1:0]   fault_pc_q, fault_pc_d;
    logic [31:0]       count_q, count_d;
    logic              req;
    logic              buf_free;

    assign buf_free = !if_valid_q || !bus.id_stall;

    always_comb begin
        state_d    = state_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_insn_d  = if_insn_q;
        misalign_d = 1'b0;
        fault_pc_d = fault_pc_q;
        count_d    = count_q;
        pc_next    = pc_cur;
        req        = 1'b0;

        case (state_q)
            BOOT: begin
                pc_next = RESET_VECTOR;
                state_d = RUN;
            end
            default: begin
                // Request is held low on redirect/trap cycles: anything
                // fetched at pc_cur would be discarded anyway.
                if (trap_valid) begin
                    pc_next    = TRAP_VECTOR;
                    if_valid_d = 1'b0;
                    state_d    = BUBBLE;
                end else if (redirect_valid) begin
                    if (redirect_target[1:0] != 2'b00) begin
                        pc_next    = TRAP_VECTOR;
                        fault_pc_d = redirect_target;
                        misalign_d = 1'b1;
                    end else begin
                        pc_next = redirect_target;
                    end
                    if_valid_d = 1'b0;
                    state_d    = BUBBLE;
                end else if (state_q == BUBBLE) begin
                    state_d = RUN;
                end else begin
                    req = buf_free;
                    if (req && bus.imem_gnt) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_cur;
                        if_insn_d  = bus.imem_rdata;
                        pc_next    = pc_cur + XLEN'(PC_INC);
                        count_d    = count_q + 32'd1;
                    end else if (if_valid_q && !bus.id_stall) begin
                        if_valid_d = 1'b0;
                    end
                end
            end
        endcase

        if (reset) begin
            pc_next = RESET_VECTOR;
            req     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= BOOT;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_insn_q  <= '0;
            misalign_q <= 1'b0;
            fault_pc_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_insn_q  <= if_insn_d;
            misalign_q <= misalign_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_cur;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_insn   = if_insn_q;
    assign misalign_err  = misalign_q;
    assign fault_pc      = fault_pc_q;
    assign fetch_count   = count_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios followed by randomized
// traffic, all compared against a cycle-level behavioural model. The bench
// also plays the Program_Counter register, feeding the model's PC to pc_cur.
module tb_pc_fetch_sequencer;

    localparam logic [63:0] RV = 64'h0;
    localparam logic [63:0] TV = 64'h100;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] pc_cur;
    logic [63:0] pc_next;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        trap_valid;
    logic        misalign_err;
    logic [63:0] fault_pc;
    logic [31:0] fetch_count;

    always #5 clock = ~clock;

    pc_fetch_sequencer_if bus ();

    pc_fetch_sequencer dut (
        .clock           (clock),
        .reset           (reset),
        .pc_cur          (pc_cur),
        .pc_next         (pc_next),
        .bus             (bus),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .misalign_err    (misalign_err),
        .fault_pc        (fault_pc),
        .fetch_count     (fetch_count)
    );

    int checks = 0;
    int errors = 0;

    // Model state: phase is the spec-level mode the sequencer is in.
    bit          m_known = 0;
    bit          m_in_boot;
    bit          m_in_bubble;
    logic [63:0] m_pc = 64'h0;
    bit          m_if_valid;
    logic [63:0] m_if_pc;
    logic [31:0] m_if_insn;
    bit          m_err;
    logic [63:0] m_fault;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, compare at the
    // falling edge, advance the model (and the PC register) at the next edge.
    task automatic cycle(input logic rst, input logic gnt, input logic stall,
                         input logic rv, input logic [63:0] tgt, input logic tv,
                         input logic [31:0] rd);
        logic [63:0] e_next;
        logic        e_req;
        bit          req_known;
        bit          n_boot, n_bubble, n_ifv, n_err;
        logic [63:0] n_ifpc, n_fault;
        logic [31:0] n_insn, n_cnt;

        reset           = rst;
        bus.imem_gnt    = gnt;
        bus.id_stall    = stall;
        bus.imem_rdata  = rd;
        redirect_valid  = rv;
        redirect_target = tgt;
        trap_valid      = tv;
        pc_cur          = m_pc;

        n_boot = 0; n_bubble = 0; n_ifv = m_if_valid; n_err = 0;
        n_ifpc = m_if_pc; n_insn = m_if_insn; n_fault = m_fault; n_cnt = m_cnt;
        e_next = m_pc; e_req = 0; req_known = 1;

        if (rst) begin
            e_next = RV;
            n_boot = 1; n_ifv = 0; n_ifpc = 0; n_insn = 0; n_fault = 0; n_cnt = 0;
        end else if (m_in_boot) begin
            e_next = RV;
        end else if (tv || rv) begin
            req_known = 0;
            n_bubble  = 1;
            n_ifv     = 0;
            if (tv) e_next = TV;
            else if (tgt[1:0] != 2'b00) begin
                e_next = TV; n_fault = tgt; n_err = 1;
            end else e_next = tgt;
        end else if (!m_in_bubble) begin
            e_req = !m_if_valid || !stall;
            if (e_req && gnt) begin
                n_ifv = 1; n_ifpc = m_pc; n_insn = rd;
                e_next = m_pc + 64'd4; n_cnt = m_cnt + 1;
            end else if (m_if_valid && !stall) begin
                n_ifv = 0;
            end
        end

        @(negedge clock);
        chk("pc_next", pc_next, e_next);
        chk("imem_addr", bus.imem_addr, m_pc);
        if (req_known) chk("imem_req", {63'b0, bus.imem_req}, {63'b0, e_req});
        if (m_known) begin
            chk("if_valid", {63'b0, bus.if_valid}, {63'b0, m_if_valid});
            chk("if_pc", bus.if_pc, m_if_pc);
            chk("if_insn", {32'b0, bus.if_insn}, {32'b0, m_if_insn});
            chk("misalign_err", {63'b0, misalign_err}, {63'b0, m_err});
            chk("fault_pc", fault_pc, m_fault);
            chk("fetch_count", {32'b0, fetch_count}, {32'b0, m_cnt});
        end

        @(posedge clock);
        #1;
        if (rst) m_known = 1;
        m_in_boot = n_boot; m_in_bubble = n_bubble; m_if_valid = n_ifv;
        m_if_pc = n_ifpc; m_if_insn = n_insn; m_err = n_err; m_fault = n_fault;
        m_cnt = n_cnt; m_pc = e_next;
    endtask

    task automatic run(input logic gnt, input logic stall, input logic [31:0] rd);
        cycle(1'b0, gnt, stall, 1'b0, 64'h0, 1'b0, rd);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
        run(1'b1, 1'b0, 32'h0);  // BOOT cycle, no request
    endtask

    initial begin
        reset = 1'b1; bus.imem_gnt = 1'b0; bus.id_stall = 1'b0; bus.imem_rdata = '0;
        redirect_valid = 1'b0; redirect_target = '0; trap_valid = 1'b0; pc_cur = '0;
        @(posedge clock);
        #1;

        // Sequential fetch from the reset vector.
        do_reset();
        for (int i = 0; i < 4; i++) run(1'b1, 1'b0, 32'h1000_0000 + i);
        chk("t1_count", {32'b0, fetch_count}, 64'd4);
        chk("t1_if_pc", bus.if_pc, 64'hC);
        chk("t1_if_insn", {32'b0, bus.if_insn}, 64'h1000_0003);
        chk("t1_pc", m_pc, 64'h10);

        // Wait states at 0x8.
        do_reset();
        run(1'b1, 1'b0, 32'h11);
        run(1'b1, 1'b0, 32'h22);
        for (int i = 0; i < 3; i++) run(1'b0, 1'b0, 32'hDEAD);
        chk("t2_if_valid", {63'b0, bus.if_valid}, 64'd0);
        chk("t2_pc", m_pc, 64'h8);
        run(1'b1, 1'b0, 32'hCAFE_0013);
        chk("t2_if_pc", bus.if_pc, 64'h8);
        chk("t2_if_insn", {32'b0, bus.if_insn}, 64'hCAFE_0013);
        chk("t2_count", {32'b0, fetch_count}, 64'd3);

        // Decode stall holds the buffer and the PC.
        do_reset();
        run(1'b1, 1'b0, 32'hAAAA);
        run(1'b1, 1'b0, 32'hBBBB);
        run(1'b1, 1'b1, 32'hCCCC);
        run(1'b1, 1'b1, 32'hCCCC);
        chk("t3_if_pc", bus.if_pc, 64'h4);
        chk("t3_if_insn", {32'b0, bus.if_insn}, 64'hBBBB);
        chk("t3_pc", m_pc, 64'h8);
        run(1'b1, 1'b0, 32'hDDDD);
        chk("t3_if_pc_after", bus.if_pc, 64'h8);

        // Aligned redirect and its bubble.
        do_reset();
        for (int i = 0; i < 4; i++) run(1'b1, 1'b0, 32'h5);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 64'h40, 1'b0, 32'h0);
        chk("t4_pc", m_pc, 64'h40);
        chk("t4_if_valid", {63'b0, bus.if_valid}, 64'd0);
        run(1'b1, 1'b0, 32'h0);
        chk("t4_bubble_count", {32'b0, fetch_count}, 64'd4);
        run(1'b1, 1'b0, 32'h4040);
        chk("t4_if_pc", bus.if_pc, 64'h40);
        chk("t4_pc_after", m_pc, 64'h44);

        // Misaligned redirect, then trap beating a redirect inside the bubble.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 64'h42, 1'b0, 32'h0);
        chk("t5_pc", m_pc, 64'h100);
        chk("t5_err", {63'b0, misalign_err}, 64'd1);
        chk("t5_fault", fault_pc, 64'h42);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 64'h40, 1'b1, 32'h0);
        chk("t5_trap_pc", m_pc, 64'h100);
        chk("t5_err_pulse", {63'b0, misalign_err}, 64'd0);

        // PC wrap at the top of the address space, then reset under stall.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'h0);
        run(1'b1, 1'b0, 32'h0);
        run(1'b1, 1'b0, 32'h7777);
        chk("t6_wrap_pc", m_pc, 64'h0);
        chk("t6_if_pc", bus.if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        run(1'b1, 1'b1, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 32'h0);
        chk("t6_rst_if_valid", {63'b0, bus.if_valid}, 64'd0);
        chk("t6_rst_count", {32'b0, fetch_count}, 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst, r_gnt, r_stall, r_rv, r_tv;
            logic [63:0] r_tgt;
            r_rst   = ($urandom_range(0, 99) == 0);
            r_gnt   = ($urandom_range(0, 3) != 0);
            r_stall = ($urandom_range(0, 9) < 3);
            r_rv    = ($urandom_range(0, 9) == 0);
            r_tv    = ($urandom_range(0, 24) == 0);
            r_tgt   = {$urandom(), $urandom()};
            if ($urandom_range(0, 1) == 0) r_tgt[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) r_tgt[63:8] = '1;
            cycle(r_rst, r_gnt, r_stall, r_rv, r_tgt, r_tv, $urandom());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
